sprite_renderer: RTL and testbench

//  Display-side initiator for a 128x64x12b sprite-sheet ROM (2-cycle read: address reg, then data reg).
//  - Maps VGA scan coordinates onto sprite-local {y[5:0],x[6:0]} requests.
//  - Selects the animation frame and handles horizontal mirroring.
//  - Re-aligns the returned colour with the scan, keys out transparency and muxes over the background RGB.
//  - Sits between the VGA sync generator and the pixel output register.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_anim_ctrl.sv | 67 ++++++
 rtl/sprite_renderer.sv | 127 ++++++++++++
 tb/tb_sprite_renderer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ============================================================================
// Module : sprite_pkg
// Brief  : Shared constants and types for the sprite renderer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int SHEET_W  = 128;
    localparam int SHEET_H  = 64;
    localparam int COLOR_W  = 12;
    localparam int COORD_W  = 10;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [COLOR_W-1:0] KEY_COLOR_DEF = 12'hF0F;

    typedef logic [COLOR_W-1:0] rgb12_t;

endpackage

`default_nettype wire

// File: rtl/sprite_anim_ctrl.sv
// ============================================================================
// Module : sprite_anim_ctrl
// Brief  : Frame-boundary shadow registers and animation frame counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 4,
    parameter int ANIM_DIV    = 6,
    parameter int FRAME_IDX_W = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   anim_en,
    input  logic [COORD_W-1:0]     sprite_x,
    input  logic [COORD_W-1:0]     sprite_y,
    input  logic                   mirror,
    output logic [COORD_W-1:0]     sx_sh,
    output logic [COORD_W-1:0]     sy_sh,
    output logic                   mirror_sh,
    output logic [FRAME_IDX_W-1:0] anim_frame
);

    localparam int c_cnt_w = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [COORD_W-1:0]     r_sx_sh;
    logic [COORD_W-1:0]     r_sy_sh;
    logic                   r_mirror_sh;
    logic [c_cnt_w-1:0]     r_anim_cnt;
    logic [FRAME_IDX_W-1:0] r_anim_frame;

    // Everything updates only at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sx_sh      <= '0;
            r_sy_sh      <= '0;
            r_mirror_sh  <= 1'b0;
            r_anim_cnt   <= '0;
            r_anim_frame <= '0;
        end else if (frame_start) begin
            r_sx_sh     <= sprite_x;
            r_sy_sh     <= sprite_y;
            r_mirror_sh <= mirror;
            if (anim_en) begin
                if (r_anim_cnt == c_cnt_w'(ANIM_DIV - 1)) begin
                    r_anim_cnt   <= '0;
                    r_anim_frame <= (r_anim_frame == FRAME_IDX_W'(NUM_FRAMES - 1))
                                    ? '0 : r_anim_frame + 1'b1;
                end else begin
                    r_anim_cnt <= r_anim_cnt + 1'b1;
                end
            end
        end
    end

    assign sx_sh      = r_sx_sh;
    assign sy_sh      = r_sy_sh;
    assign mirror_sh  = r_mirror_sh;
    assign anim_frame = r_anim_frame;

endmodule

`default_nettype wire

// File: rtl/sprite_renderer.sv
// ============================================================================
// Module : sprite_renderer
// Brief  : Maps scan coordinates to sprite-sheet ROM reads and composites
//          the returned colour over the background with a fixed latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int     FRAME_W    = 32,
    parameter int     FRAME_H    = 64,
    parameter int     NUM_FRAMES = 4,
    parameter int     ANIM_DIV   = 6,
    parameter rgb12_t KEY_COLOR  = KEY_COLOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COORD_W-1:0] sprite_x,
    input  logic [COORD_W-1:0] sprite_y,
    input  logic               mirror,
    input  logic               anim_en,
    input  logic [COLOR_W-1:0] bg_rgb,
    output logic [6:0]         rom_x,
    output logic [5:0]         rom_y,
    output logic               rom_en,
    input  logic [COLOR_W-1:0] rom_color,
    output logic [COLOR_W-1:0] rgb,
    output logic               rgb_valid
);

    localparam int c_frame_idx_w = $clog2(SHEET_W);
    localparam int c_row_w       = $clog2(SHEET_H);

    logic [COORD_W-1:0]       w_sx_sh;
    logic [COORD_W-1:0]       w_sy_sh;
    logic                     w_mirror_sh;
    logic [c_frame_idx_w-1:0] w_anim_frame;

    sprite_anim_ctrl #(
        .NUM_FRAMES  (NUM_FRAMES),
        .ANIM_DIV    (ANIM_DIV),
        .FRAME_IDX_W (c_frame_idx_w)
    ) u_anim_ctrl (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .anim_en     (anim_en),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .mirror      (mirror),
        .sx_sh       (w_sx_sh),
        .sy_sh       (w_sy_sh),
        .mirror_sh   (w_mirror_sh),
        .anim_frame  (w_anim_frame)
    );

    // Zero-extended subtraction gives an 11-bit signed offset: no wrap-around.
    logic [COORD_W:0]         w_dx;
    logic [COORD_W:0]         w_dy;
    logic                     w_hit;
    logic [6:0]               w_col;
    logic [6:0]               w_frame_base;
    logic [6:0]               w_rom_x;

    assign w_dx  = {1'b0, pixel_x} - {1'b0, w_sx_sh};
    assign w_dy  = {1'b0, pixel_y} - {1'b0, w_sy_sh};
    assign w_hit = video_on
                 && !w_dx[COORD_W] && (w_dx[COORD_W-1:0] < COORD_W'(FRAME_W))
                 && !w_dy[COORD_W] && (w_dy[COORD_W-1:0] < COORD_W'(FRAME_H));

    assign w_col        = w_mirror_sh ? (7'(FRAME_W - 1) - w_dx[6:0]) : w_dx[6:0];
    assign w_frame_base = 7'(w_anim_frame * 7'(FRAME_W));
    assign w_rom_x      = w_frame_base + w_col;

    logic [6:0]         r_rom_x;
    logic [5:0]         r_rom_y;
    logic               r_rom_en;
    logic [2:0]         r_hit_d;
    logic [2:0]         r_von_d;
    rgb12_t [2:0]       r_bg_d;
    rgb12_t             r_rgb;
    logic               r_rgb_valid;

    // Three-deep delay line matches the address register plus the 2-cycle ROM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_x     <= '0;
            r_rom_y     <= '0;
            r_rom_en    <= 1'b0;
            r_hit_d     <= '0;
            r_von_d     <= '0;
            r_bg_d      <= '0;
            r_rgb       <= '0;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rom_en    <= 1'b1;
            r_rom_x     <= w_hit ? w_rom_x : '0;
            r_rom_y     <= w_hit ? w_dy[c_row_w-1:0] : '0;
            r_hit_d     <= {r_hit_d[1:0], w_hit};
            r_von_d     <= {r_von_d[1:0], video_on};
            r_bg_d      <= {r_bg_d[1:0], rgb12_t'(bg_rgb)};
            r_rgb_valid <= r_von_d[2];
            if (!r_von_d[2]) begin
                r_rgb <= '0;
            end else if (r_hit_d[2] && (rom_color != KEY_COLOR)) begin
                r_rgb <= rom_color;
            end else begin
                r_rgb <= r_bg_d[2];
            end
        end
    end

    assign rom_x     = r_rom_x;
    assign rom_y     = r_rom_y;
    assign rom_en    = r_rom_en;
    assign rgb       = r_rgb;
    assign rgb_valid = r_rgb_valid;

endmodule

`default_nettype wire

// File: tb/tb_sprite_renderer.sv
// ============================================================================
// Module : tb_sprite_renderer
// Brief  : Self-checking bench for sprite_renderer against a pixel-level model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_renderer;

    localparam int          FW   = 32;
    localparam int          FH   = 64;
    localparam int          NF   = 4;
    localparam int          ADIV = 6;
    localparam logic [11:0] KEY  = 12'hF0F;
    localparam int          NCYC = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic        mirror = 1'b0;
    logic        anim_en = 1'b0;
    logic [11:0] bg_rgb = '0;
    logic [6:0]  rom_x;
    logic [5:0]  rom_y;
    logic        rom_en;
    logic [11:0] rom_color = '0;
    logic [11:0] rgb;
    logic        rgb_valid;

    always #5 clk = ~clk;

    sprite_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .mirror      (mirror),
        .anim_en     (anim_en),
        .bg_rgb      (bg_rgb),
        .rom_x       (rom_x),
        .rom_y       (rom_y),
        .rom_en      (rom_en),
        .rom_color   (rom_color),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid)
    );

    // Sheet contents: every column with x%8==3 is transparent.
    function automatic logic [11:0] rom_word(input int y, input int x);
        int c;
        if (x % 8 == 3) return KEY;
        c = (x * 13 + y * 157 + 677) % 4096;
        if (c == int'(KEY)) c = c ^ 1;
        return 12'(c);
    endfunction

    // Two-cycle ROM: address register, then data register.
    logic [12:0] rom_addr_q = '0;
    always @(posedge clk) begin
        if (rom_en) rom_addr_q <= {rom_y, rom_x};
        rom_color <= rom_word(int'(rom_addr_q[12:7]), int'(rom_addr_q[6:0]));
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Expectations indexed by the negedge at which they become observable.
    bit          e_addr_ok [NCYC];
    logic [6:0]  e_rx      [NCYC];
    logic [5:0]  e_ry      [NCYC];
    bit          e_ren     [NCYC];
    bit          e_rgb_ok  [NCYC];
    logic [11:0] e_rgb     [NCYC];
    bit          e_rv      [NCYC];

    // Model state: what the renderer should have latched at the last frame boundary.
    int m_sx = 0, m_sy = 0, m_mir = 0, m_frame = 0, m_cnt = 0;
    int t_sx = 0, t_sy = 0, t_mir = 0, t_aen = 0;

    task automatic step(input bit rst, input bit vo, input bit fs,
                        input int px, input int py, input logic [11:0] bg);
        int k, a1, a4, dx, dy, col, ax, ay;
        bit hit;
        logic [11:0] c;
        @(negedge clk);
        k = cyc % NCYC;
        if (e_addr_ok[k]) begin
            check_eq("rom_x", 32'(rom_x), 32'(e_rx[k]));
            check_eq("rom_y", 32'(rom_y), 32'(e_ry[k]));
            check_eq("rom_en", 32'(rom_en), 32'(e_ren[k]));
        end
        if (e_rgb_ok[k]) begin
            check_eq("rgb", 32'(rgb), 32'(e_rgb[k]));
            check_eq("rgb_valid", 32'(rgb_valid), 32'(e_rv[k]));
        end
        e_addr_ok[k] = 1'b0;
        e_rgb_ok[k]  = 1'b0;

        reset       = rst;
        video_on    = vo;
        frame_start = fs;
        pixel_x     = 10'(px);
        pixel_y     = 10'(py);
        bg_rgb      = bg;
        sprite_x    = 10'(t_sx);
        sprite_y    = 10'(t_sy);
        mirror      = t_mir[0];
        anim_en     = t_aen[0];

        a1 = (cyc + 1) % NCYC;
        a4 = (cyc + 4) % NCYC;
        if (rst) begin
            e_addr_ok[a1] = 1'b1; e_rx[a1] = '0; e_ry[a1] = '0; e_ren[a1] = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                e_rgb_ok[(cyc + i) % NCYC] = 1'b1;
                e_rgb[(cyc + i) % NCYC]    = '0;
                e_rv[(cyc + i) % NCYC]     = 1'b0;
            end
            m_sx = 0; m_sy = 0; m_mir = 0; m_frame = 0; m_cnt = 0;
        end else begin
            dx  = px - m_sx;
            dy  = py - m_sy;
            hit = vo && dx >= 0 && dx < FW && dy >= 0 && dy < FH;
            col = (m_mir != 0) ? FW - 1 - dx : dx;
            ax  = hit ? (m_frame * FW + col) % 128 : 0;
            ay  = hit ? dy : 0;
            e_addr_ok[a1] = 1'b1; e_rx[a1] = 7'(ax); e_ry[a1] = 6'(ay); e_ren[a1] = 1'b1;
            c = rom_word(ay, ax);
            e_rgb_ok[a4] = 1'b1;
            e_rgb[a4]    = !vo ? 12'h000 : ((hit && c != KEY) ? c : bg);
            e_rv[a4]     = vo;
            if (fs) begin
                m_sx = t_sx; m_sy = t_sy; m_mir = t_mir;
                if (t_aen != 0) begin
                    if (m_cnt == ADIV - 1) begin
                        m_cnt   = 0;
                        m_frame = (m_frame + 1) % NF;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic pix(input int px, input int py, input logic [11:0] bg);
        step(1'b0, 1'b1, 1'b0, px, py, bg);
    endtask

    task automatic pulse();
        step(1'b0, 1'b0, 1'b1, 0, 0, 12'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 12'($urandom));
    endtask

    initial begin
        int px, py;
        bit rst, fs, vo;

        // Reset held with active video
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 100 + i, 60, 12'($urandom));
        idle(1);

        // Plain hit and left-edge miss
        t_sx = 100; t_sy = 50; t_mir = 0; t_aen = 0;
        pulse();
        pix(105, 60, 12'($urandom));
        pix(99, 60, 12'h5A5);
        pix(131, 60, 12'($urandom));
        pix(132, 60, 12'($urandom));
        pix(100, 113, 12'($urandom));
        pix(100, 114, 12'($urandom));
        pix(100, 49, 12'($urandom));
        idle(4);

        // Mirror with frame 2
        t_mir = 1; t_aen = 1;
        for (int i = 0; i < 12; i++) pulse();
        t_aen = 0;
        pix(100, 50, 12'($urandom));
        pix(131, 50, 12'($urandom));
        // Transparent texel (sheet column 91) and a blanked pixel in the box
        pix(104, 55, 12'h123);
        step(1'b0, 1'b0, 1'b0, 104, 55, 12'h321);
        idle(4);

        // Animation wrap, then freeze
        t_mir = 0; t_aen = 1;
        for (int i = 0; i < 24; i++) begin
            pulse();
            pix(100, 50, 12'($urandom));
            pix(103 + (i % 4), 51, 12'($urandom));
        end
        t_aen = 0;
        for (int i = 0; i < 10; i++) begin
            pulse();
            pix(101, 52, 12'($urandom));
        end
        idle(4);

        // Mid-frame position change must not show until the next boundary
        t_sx = 200;
        pix(100, 50, 12'($urandom));
        pix(200, 50, 12'($urandom));
        pulse();
        pix(100, 50, 12'($urandom));
        pix(200, 50, 12'($urandom));

        // Right-edge clipping without wrap
        t_sx = 630; t_sy = 50;
        pulse();
        for (int x = 620; x < 640; x++) pix(x, 60, 12'($urandom));
        for (int x = 0; x < 16; x++)    pix(x, 60, 12'($urandom));
        idle(4);

        // Randomised traffic, including mid-line resets and boundary latches
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                t_sx  = $urandom_range(0, 700);
                t_sy  = $urandom_range(0, 500);
                t_mir = $urandom_range(0, 1);
                t_aen = ($urandom_range(0, 3) != 0) ? 1 : 0;
            end
            rst = ($urandom_range(0, 399) == 0);
            fs  = ($urandom_range(0, 29) == 0);
            vo  = ($urandom_range(0, 7) != 0);
            px  = m_sx + int'($urandom_range(0, 40)) - 4;
            py  = m_sy + int'($urandom_range(0, 72)) - 4;
            if (px < 0) px = 0;
            if (px > 1023) px = 1023;
            if (py < 0) py = 0;
            if (py > 1023) py = 1023;
            step(rst, vo, fs, px, py, 12'($urandom));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
